cam_pixel_capture: RTL and testbench
====================================

# cam_pixel_capture

Captures the 8-bit parallel camera bus (PCLK/HREF/VSYNC/D[7:0]) into the system clock domain and reassembles byte pairs into 16-bit RGB565 pixels with column/row coordinates. It sits directly upstream of the pixel-event counting stage: `pixel_valid_out` is the one-cycle event strobe that drives an `evt_counter` `evt_in`. The same strobe and coordinates feed the stereo frame buffers.

## Interface

Parameters:
- `H_PIXELS`, 320: active pixels per line.
- `V_LINES`, 240: active lines per frame.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers (≥2).

Ports:
- `clk_in`  input  1  system clock; must be ≥3× `cam_pclk_in` frequency.
- `rst_in`  input  1  asynchronous, active-high reset.
- `cam_pclk_in`  input  1  camera pixel clock, asynchronous to `clk_in`.
- `cam_href_in`  input  1  high during active line bytes.
- `cam_vsync_in`  input  1  high marks frame start/blanking.
- `cam_data_in`  input  8  camera byte bus.
- `pixel_valid_out`  output  1  one-cycle strobe per completed pixel.
- `pixel_data_out`  output  16  `{first_byte, second_byte}` RGB565.
- `hcount_out`  output  `$clog2(H_PIXELS)`  column of the presented pixel.
- `vcount_out`  output  `$clog2(V_LINES)`  row of the presented pixel.
- `frame_done_out`  output  1  one-cycle pulse after the last line of a frame.
- `line_error_out`  output  1  one-cycle pulse on a malformed line.

## Operation

- The design passes all four camera inputs through identical `SYNC_STAGES`-deep synchronizers. It registers the last synchronized PCLK and defines a sample event as a synchronized PCLK rising edge (prev 0, now 1). HREF, VSYNC and DATA are taken from the same synchronizer stage as PCLK.
- FSM states:
  - **WAIT_FRAME**: on a sample with VSYNC=1, clear the column and row counters and go to HI.
  - **HI**:
    - Sample with HREF=1: latch the byte as the high byte, go to LO.
    - HREF falling (previous sampled HREF=1, now 0): end of line. Go to END_LINE.
  - **LO**:
    - Sample with HREF=1: emit the pixel `{hi, byte}` and go to HI.
    - Sample with HREF=0 (odd byte count): discard the high byte, pulse `line_error_out`, then handle end of line exactly as in HI.
  - **END_LINE** (single cycle):
    - If the column count ≠ `H_PIXELS`, pulse `line_error_out`.
    - Clear the column count and increment the row.
    - If the finished row was `V_LINES`-1, pulse `frame_done_out` and go to WAIT_FRAME. Otherwise go to HI.
- Pixel emit:
  - If column < `H_PIXELS`, assert `pixel_valid_out`, drive the data and coordinates, and increment the column.
  - Otherwise drop the pixel with no strobe. The internal column counter saturates at `H_PIXELS`, and the line is flagged at END_LINE.
- VSYNC=1 on any sample while in HI, LO or END_LINE aborts the frame:
  - Counters are cleared and the FSM restarts at HI.
  - No `frame_done_out` is issued, and the partial line does not raise `line_error_out`.
- Lines arriving after the last row, before VSYNC, are ignored in WAIT_FRAME.
- `pixel_data_out`, `hcount_out` and `vcount_out` hold their last values between strobes.
- Reset: all outputs 0, FSM in WAIT_FRAME, synchronizers and counters 0. Assertion mid-line drops the partial pixel immediately.

## Timing

- Latency: `pixel_valid_out` rises exactly `SYNC_STAGES`+2 `clk_in` cycles after the first `clk_in` edge that samples `cam_pclk_in` high for the second byte.
- `pixel_valid_out`, `frame_done_out` and `line_error_out` are registered and high for exactly one cycle.
- Minimum spacing between `pixel_valid_out` strobes: 2 PCLK periods.
- `frame_done_out` follows the final pixel's strobe by at least 1 cycle. It is never coincident with `pixel_valid_out`.
- `line_error_out` may coincide with `frame_done_out`.
- Odd-byte error: `line_error_out` is issued in the cycle after the offending sample, and the END_LINE error check in the following cycle is suppressed for that line.
- Counter arithmetic is unsigned. There is no wrap: the row index never exceeds `V_LINES`-1 because the FSM returns to WAIT_FRAME first.

## Structure

- Package `cam_pkg`: FSM state enum (`WAIT_FRAME`, `HI`, `LO`, `END_LINE`), `rgb565_t` packed struct (5/6/5), and default resolution constants.
- Sub-module `sync_chain` (parameterised width and depth, async reset) is instantiated once for the 11-bit camera bundle.
- The rest is a single always_ff FSM plus counters.

## Test plan

- **Normal frame**: VSYNC pulse, then 240 lines of 640 bytes with an incrementing byte pattern at PCLK = `clk_in`/4.
  - Expect 76800 strobes; pixel 0 = 0x0001 at (0,0); last pixel at (319,239).
  - Expect exactly 1 `frame_done_out` and 0 `line_error_out`.
- **Odd-byte line**: 639 bytes on line 5.
  - Expect 319 strobes and 1 `line_error_out` on that line.
  - Line 6 starts at hcount 0 with correct byte pairing.
- **Long line**: 660 bytes.
  - Expect 320 strobes (hcount max 319), 10 pixels dropped, 1 `line_error_out`.
- **Mid-frame VSYNC**: VSYNC asserted during line 100.
  - Expect no `frame_done_out`; the next strobe is at (0,0).
- **Reset mid-line**: `rst_in` pulsed after 3 bytes of line 2.
  - All outputs are 0 immediately; no strobe until the next VSYNC.
- **Latency check**: single pixel with `SYNC_STAGES`=3.
  - Strobe exactly 5 cycles after the second byte's PCLK is first sampled high.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera pixel capture path.
package cam_pkg;

  localparam int DEF_H_PIXELS    = 320;
  localparam int DEF_V_LINES     = 240;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    HI,
    LO,
    END_LINE
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef struct packed {
    logic       pclk;
    logic       href;
    logic       vsync;
    logic [7:0] data;
  } cam_bus_t;

  function automatic rgb565_t pack_pixel(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera byte bus in, reassembled pixel stream out.
interface cam_pixel_capture_if
  import cam_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int V_LINES  = DEF_V_LINES
);
  localparam int HW = $clog2(H_PIXELS);
  localparam int VW = $clog2(V_LINES);

  logic          cam_pclk_in;
  logic          cam_href_in;
  logic          cam_vsync_in;
  logic [7:0]    cam_data_in;
  logic          pixel_valid_out;
  rgb565_t       pixel_data_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          frame_done_out;
  logic          line_error_out;

  modport master (
    output cam_pclk_in, cam_href_in, cam_vsync_in, cam_data_in,
    input  pixel_valid_out, pixel_data_out, hcount_out, vcount_out,
    input  frame_done_out, line_error_out
  );

  modport slave (
    input  cam_pclk_in, cam_href_in, cam_vsync_in, cam_data_in,
    output pixel_valid_out, pixel_data_out, hcount_out, vcount_out,
    output frame_done_out, line_error_out
  );
endinterface

// File: rtl/sync_chain.sv
// Multi-bit flip-flop synchronizer; every bit sees the same depth.
module sync_chain #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];
endmodule

// File: rtl/cam_pixel_capture.sv
// Camera byte-pair capture into RGB565 pixels with column/row coordinates.
// state      | meaning
// WAIT_FRAME | idle until a VSYNC sample starts a frame
// HI         | expecting the first byte of a pixel, or end of line
// LO         | first byte held, expecting the second byte
// END_LINE   | one-cycle line wrap-up: length check, row advance
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int H_PIXELS    = DEF_H_PIXELS,
  parameter int V_LINES     = DEF_V_LINES,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic               clk_in,
  input logic               rst_in,
  cam_pixel_capture_if.slave bus
);
  localparam int HW = $clog2(H_PIXELS);
  localparam int CW = $clog2(H_PIXELS + 1);
  localparam int VW = $clog2(V_LINES);
  localparam logic [CW-1:0] H_MAX  = CW'(H_PIXELS);
  localparam logic [VW-1:0] V_LAST = VW'(V_LINES - 1);

  cam_bus_t raw, synced, cap;
  logic       pclk_prev, smp, href_q, vsync_q;
  logic [7:0] data_q;

  assign raw = {bus.cam_pclk_in, bus.cam_href_in, bus.cam_vsync_in, bus.cam_data_in};

  sync_chain #(.WIDTH($bits(cam_bus_t)), .DEPTH(SYNC_STAGES)) u_sync (
    .clk (clk_in),
    .rst (rst_in),
    .d   (raw),
    .q   (synced)
  );

  // Two retime stages keep the sample strobe and its byte aligned.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cap       <= '0;
      pclk_prev <= 1'b0;
      smp       <= 1'b0;
      href_q    <= 1'b0;
      vsync_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      cap       <= synced;
      pclk_prev <= cap.pclk;
      smp       <= cap.pclk & ~pclk_prev;
      href_q    <= cap.href;
      vsync_q   <= cap.vsync;
      data_q    <= cap.data;
    end
  end

  state_t        state;
  logic [CW-1:0] col;
  logic [VW-1:0] row;
  logic [7:0]    hi_byte;
  logic          href_prev, err_sup, overrun;
  logic          pixel_valid, frame_done, line_error;
  rgb565_t       pixel_data;
  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= WAIT_FRAME;
      col         <= '0;
      row         <= '0;
      hi_byte     <= '0;
      href_prev   <= 1'b0;
      err_sup     <= 1'b0;
      overrun     <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= '0;
      hcount      <= '0;
      vcount      <= '0;
      frame_done  <= 1'b0;
      line_error  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      line_error  <= 1'b0;
      if (smp) href_prev <= href_q;

      if (smp && vsync_q && state != WAIT_FRAME) begin
        // Frame abort: silently restart, the partial line is not judged.
        col     <= '0;
        row     <= '0;
        err_sup <= 1'b0;
        overrun <= 1'b0;
        state   <= HI;
      end else begin
        case (state)
          WAIT_FRAME: begin
            if (smp && vsync_q) begin
              col     <= '0;
              row     <= '0;
              err_sup <= 1'b0;
              overrun <= 1'b0;
              state   <= HI;
            end
          end
          HI: begin
            if (smp && href_q) begin
              hi_byte <= data_q;
              state   <= LO;
            end else if (smp && href_prev) begin
              state <= END_LINE;
            end
          end
          LO: begin
            if (smp && href_q) begin
              if (col < H_MAX) begin
                pixel_valid <= 1'b1;
                pixel_data  <= pack_pixel(hi_byte, data_q);
                hcount      <= col[HW-1:0];
                vcount      <= row;
                col         <= col + 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= HI;
            end else if (smp) begin
              line_error <= 1'b1;
              err_sup    <= 1'b1;
              state      <= END_LINE;
            end
          end
          END_LINE: begin
            if (!err_sup && (col != H_MAX || overrun)) line_error <= 1'b1;
            col     <= '0;
            err_sup <= 1'b0;
            overrun <= 1'b0;
            if (row == V_LAST) begin
              row        <= '0;
              frame_done <= 1'b1;
              state      <= WAIT_FRAME;
            end else begin
              row   <= row + 1'b1;
              state <= HI;
            end
          end
          default: state <= WAIT_FRAME;
        endcase
      end
    end
  end

  assign bus.pixel_valid_out = pixel_valid;
  assign bus.pixel_data_out  = pixel_data;
  assign bus.hcount_out      = hcount;
  assign bus.vcount_out      = vcount;
  assign bus.frame_done_out  = frame_done;
  assign bus.line_error_out  = line_error;
endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomized bench for cam_pixel_capture against a line-level pixel model.
module tb_cam_pixel_capture;
  import cam_pkg::*;

  localparam int H = 8;
  localparam int V = 8;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cam_pixel_capture_if #(.H_PIXELS(H), .V_LINES(V)) bus ();

  cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .SYNC_STAGES(S)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    int          h;
    int          v;
  } pix_t;

  pix_t        exp_q[$];
  bit          m_active = 1'b0;
  int          m_row = 0;
  int          exp_fd = 0, exp_le = 0, got_fd = 0, got_le = 0;
  logic [15:0] last_d = '0;
  int          last_h = 0, last_v = 0;
  logic [7:0]  pat = 8'h00;

  // Model: a line of n bytes yields min(n/2, H) pixels; any length other
  // than exactly 2H bytes is one error; the last row closes the frame.
  task automatic model_line(input logic [7:0] b[$], input bit closed);
    int npix;
    if (!m_active) return;
    npix = b.size() / 2;
    for (int p = 0; p < npix && p < H; p++)
      exp_q.push_back('{d: {b[2*p], b[2*p+1]}, h: p, v: m_row});
    if (!closed) return;
    if ((b.size() % 2) != 0 || npix != H) exp_le++;
    if (m_row == V - 1) begin
      exp_fd++;
      m_active = 1'b0;
    end else begin
      m_row++;
    end
  endtask

  initial begin
    pix_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.frame_done_out) begin
        got_fd++;
        chk("fd_excl", 32'(bus.pixel_valid_out), 0);
      end
      if (bus.line_error_out) got_le++;
      if (bus.pixel_valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pix", 32'(bus.pixel_valid_out), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", 32'(bus.pixel_data_out), 32'(e.d));
          chk("pix_h", 32'(bus.hcount_out), e.h);
          chk("pix_v", 32'(bus.vcount_out), e.v);
          last_d = e.d;
          last_h = e.h;
          last_v = e.v;
        end
      end else begin
        chk("hold_d", 32'(bus.pixel_data_out), 32'(last_d));
        chk("hold_h", 32'(bus.hcount_out), last_h);
        chk("hold_v", 32'(bus.vcount_out), last_v);
      end
    end
  end

  // One PCLK period = 4 clk: low for 2, high for 2; bus changes with PCLK low.
  task automatic pclk_cycle(input logic [7:0] d, input logic h, input logic v);
    @(negedge clk);
    bus.cam_pclk_in  = 1'b0;
    bus.cam_data_in  = d;
    bus.cam_href_in  = h;
    bus.cam_vsync_in = v;
    @(negedge clk);
    @(negedge clk);
    bus.cam_pclk_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic gen_bytes(input int n, input bit rnd, output logic [7:0] b[$]);
    b = {};
    for (int k = 0; k < n; k++) begin
      b.push_back(rnd ? 8'($urandom) : pat);
      pat++;
    end
  endtask

  task automatic send_line(input int n, input bit rnd);
    logic [7:0] b[$];
    gen_bytes(n, rnd, b);
    model_line(b, 1'b1);
    foreach (b[k]) pclk_cycle(b[k], 1'b1, 1'b0);
    repeat ($urandom_range(2, 4)) pclk_cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int n);
    logic [7:0] b[$];
    gen_bytes(n, 1'b1, b);
    model_line(b, 1'b0);
    foreach (b[k]) pclk_cycle(b[k], 1'b1, 1'b0);
  endtask

  task automatic vsync_pulse();
    m_active = 1'b1;
    m_row    = 0;
    repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
    repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
  endtask

  task automatic settle(input string tag);
    repeat (24) @(negedge clk);
    chk({tag, "_fd_count"}, got_fd, exp_fd);
    chk({tag, "_le_count"}, got_le, exp_le);
    chk({tag, "_pix_left"}, exp_q.size(), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.pixel_valid_out), 0);
    chk({tag, "_data"}, 32'(bus.pixel_data_out), 0);
    chk({tag, "_hcount"}, 32'(bus.hcount_out), 0);
    chk({tag, "_vcount"}, 32'(bus.vcount_out), 0);
    chk({tag, "_fd"}, 32'(bus.frame_done_out), 0);
    chk({tag, "_le"}, 32'(bus.line_error_out), 0);
  endtask

  // Second byte of a one-pixel line, measuring clk edges to the strobe.
  task automatic latency_line();
    logic [7:0] b[$];
    int lat;
    gen_bytes(2, 1'b1, b);
    model_line(b, 1'b1);
    pclk_cycle(b[0], 1'b1, 1'b0);
    @(negedge clk);
    bus.cam_pclk_in  = 1'b0;
    bus.cam_data_in  = b[1];
    bus.cam_href_in  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.cam_pclk_in = 1'b1;
    @(posedge clk);
    lat = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.pixel_valid_out) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, S + 2);
    repeat (3) pclk_cycle(8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] tail[$];
    bus.cam_pclk_in  = 1'b0;
    bus.cam_href_in  = 1'b0;
    bus.cam_vsync_in = 1'b0;
    bus.cam_data_in  = 8'h00;
    #2 rst = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Normal frame, incrementing pattern: first pixel 0x0001 at (0,0).
    pat = 8'h00;
    vsync_pulse();
    for (int r = 0; r < V; r++) send_line(2 * H, 1'b0);
    settle("normal");

    // Long line on row 3, odd line on row 5.
    vsync_pulse();
    for (int r = 0; r < V; r++)
      send_line((r == 5) ? 2 * H - 1 : (r == 3) ? 2 * H + 4 : 2 * H, 1'b1);
    settle("odd_long");

    // Random line lengths around nominal.
    vsync_pulse();
    for (int r = 0; r < V; r++) send_line($urandom_range(2 * H - 3, 2 * H + 3), 1'b1);
    settle("random_len");

    // Extra lines after the frame end are ignored.
    send_line(2 * H, 1'b1);
    settle("post_frame");

    // VSYNC inside row 3 aborts; a full frame follows.
    vsync_pulse();
    for (int r = 0; r < 3; r++) send_line(2 * H, 1'b1);
    send_partial(5);
    vsync_pulse();
    for (int r = 0; r < V; r++) send_line(2 * H, 1'b1);
    settle("abort");

    // Reset after 3 bytes of row 2; nothing until the next VSYNC.
    vsync_pulse();
    for (int r = 0; r < 2; r++) send_line(2 * H, 1'b1);
    send_partial(3);
    repeat (3) @(negedge clk);
    rst      = 1'b1;
    m_active = 1'b0;
    last_d   = '0;
    last_h   = 0;
    last_v   = 0;
    #1 check_outputs_zero("mid_reset");
    chk("mid_reset_pix_left", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gen_bytes(2 * H - 3, 1'b1, tail);
    foreach (tail[k]) pclk_cycle(tail[k], 1'b1, 1'b0);
    repeat (3) pclk_cycle(8'h00, 1'b0, 1'b0);
    send_line(2 * H, 1'b1);
    settle("after_reset");

    vsync_pulse();
    latency_line();
    for (int r = 1; r < V; r++) send_line(2 * H, 1'b1);
    settle("latency_frame");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
